trace_sched: RTL and testbench
==============================

TRACE_SCHED -- requirements
Module: trace_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter DROP_W, default 16, drop-counter width.
REQ-003 SHALL have port gclk, input, iu_clk_type; logic clocked on rising gclk.clk.
REQ-004 SHALL have port rstn, input, 1; asynchronous, active-low reset.
REQ-005 SHALL have port trace_en, input, 1; software enable for tracing.
REQ-006 SHALL have ports cm_valid and cm_rec, input, 1 and trace_rec_type; pipeline commit record (port A).
REQ-007 SHALL have ports uc_valid and uc_rec, input, 1 and trace_rec_type; microcode/DMA record (port B).
REQ-008 SHALL have ports out_valid and out_rec, output, 1 and trace_rec_type; record to trace sink.
REQ-009 SHALL have port out_ready, input, 1; sink accepts when out_valid && out_ready.
REQ-010 SHALL have port drop_cnt, output, DROP_W; saturating count of dropped records.
REQ-011 SHALL have port state, output, 2; current FSM state.

Function
REQ-012 SHALL implement FSM IDLE(0), RUN(1), DRAIN(2).
REQ-013 IDLE->RUN SHALL occur when trace_en=1.
REQ-014 RUN->DRAIN SHALL occur when trace_en=0.
REQ-015 DRAIN->IDLE SHALL occur when the FIFO is empty.
REQ-016 DRAIN->RUN SHALL occur when trace_en=1, taking priority over DRAIN->IDLE.
REQ-017 Records SHALL be written only in RUN; inputs in IDLE/DRAIN are ignored and not counted as drops.
REQ-018 Up to two writes per cycle SHALL be accepted; when both ports are valid, port A is written before port B.
REQ-019 Free slots SHALL equal DEPTH - count + pop, where pop = out_valid && out_ready in the same cycle.
REQ-020 With 1 free slot and both ports valid, port A SHALL be written and port B dropped; with 0 free slots, all valid inputs are dropped.
REQ-021 drop_cnt SHALL increment by the number of dropped records (0..2) and saturate at all-ones, with no wrap.
REQ-022 out_valid SHALL equal FIFO non-empty; out_rec is the head entry (registered storage, no bypass).
REQ-023 Write-to-out_valid latency SHALL be 1 cycle.
REQ-024 out_rec SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-026 A simultaneous pop and double push at count=DEPTH-1 SHALL end at count=DEPTH with no drops.

Reset
REQ-027 On rstn=0, asynchronously: state=IDLE, pointers=0, count=0, out_valid=0, drop_cnt=0.
REQ-028 Reset mid-DRAIN SHALL discard buffered records.
REQ-029 out_rec value after reset SHALL be don't-care.

Configuration
REQ-030 Macro TRACE_TID_FILTER_EN SHALL add input tid_mask (64 bits) when defined.
REQ-031 With the macro defined, a record SHALL be written only if tid_mask[rec.tid]=1; filtered records are neither stored nor counted as drops.
REQ-032 Without the macro, there SHALL be no tid_mask port, and all valid records are eligible.

Structure
REQ-033 trace_rec_type SHALL be a packed 82-bit struct in libiu: tid[5:0], pc[31:0], inst[31:0], upc[7:0], replay, annul, dma_mode, uc_mode.
REQ-034 The state enum trace_sched_state_type SHALL also be in libiu.
REQ-035 Storage SHALL be the single sub-module trace_fifo_2w1r (2-write/1-read, DEPTH entries); arbitration, FSM and drop counting stay in trace_sched.

Verification
REQ-036 Reset, trace_en=1, single cm_valid with pc=0x40000010 SHALL give out_valid=1 the next cycle with out_rec.pc=0x40000010 and state=RUN.
REQ-037 Both ports valid each cycle for 4 cycles with out_ready=0 and DEPTH=8 SHALL store 8 records in order A0,B0,A1,B1..., with drop_cnt=0.
REQ-038 Continuing REQ-037 for one more cycle SHALL raise drop_cnt to 2; with 1 free slot, A is stored and drop_cnt += 1.
REQ-039 Dropping trace_en with 3 entries buffered and out_ready=1 SHALL give state DRAIN for 3 pops, then IDLE; inputs during DRAIN are ignored.
REQ-040 Forcing drop_cnt to 0xFFFE, then a double drop, SHALL hold drop_cnt at 0xFFFF.
REQ-041 With TRACE_TID_FILTER_EN and tid_mask=0x1, records with tid=1 SHALL be neither stored nor counted; records with tid=0 pass.

Source files
------------

// File: rtl/libiu.sv
// Shared IU types: clock bundle, trace record and trace scheduler states.
// Consumed by trace_sched and trace_fifo_2w1r.
package libiu;

    typedef struct packed {
        logic clk;
    } iu_clk_type;

    typedef struct packed {
        logic [5:0]  tid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [7:0]  upc;
        logic        replay;
        logic        annul;
        logic        dma_mode;
        logic        uc_mode;
    } trace_rec_type;

    typedef enum logic [1:0] {
        TS_IDLE  = 2'd0,
        TS_RUN   = 2'd1,
        TS_DRAIN = 2'd2
    } trace_sched_state_type;

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Trace record FIFO: up to two writes and one read per cycle.
// Head is read straight from registered storage.
module trace_fifo_2w1r
    import libiu::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [1:0]    wr_n,
    input  trace_rec_type wr_d0,
    input  trace_rec_type wr_d1,
    input  logic          rd_en,
    output trace_rec_type rd_d,
    output logic [CW-1:0] count,
    output logic          empty
);

    trace_rec_type mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr1;

    assign wptr1 = wptr + AW'(1);
    assign rd_d  = mem[rptr];
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (wr_n != 2'd0) mem[wptr]  <= wr_d0;
        if (wr_n == 2'd2) mem[wptr1] <= wr_d1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(wr_n);
            rptr  <= rptr + AW'(rd_en);
            count <= count + CW'(wr_n) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/trace_sched.sv
// Trace scheduler: two-port record arbitration, run/drain FSM, drop counting.
// Optional TRACE_TID_FILTER_EN adds a per-thread tid_mask write filter.
module trace_sched
    import libiu::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  iu_clk_type          gclk,
    input  logic                rstn,
    input  logic                trace_en,
    input  logic                cm_valid,
    input  trace_rec_type       cm_rec,
    input  logic                uc_valid,
    input  trace_rec_type       uc_rec,
`ifdef TRACE_TID_FILTER_EN
    input  logic [63:0]         tid_mask,
`endif
    output logic                out_valid,
    output trace_rec_type       out_rec,
    input  logic                out_ready,
    output logic [DROP_W-1:0]   drop_cnt,
    output logic [1:0]          state
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                  clk;
    trace_sched_state_type state_q;
    trace_sched_state_type state_d;
    logic [CW-1:0]         count;
    logic                  empty;
    logic                  pop;
    logic [CW-1:0]         free;
    logic                  pass_a;
    logic                  pass_b;
    logic                  elig_a;
    logic                  elig_b;
    logic                  acc_a;
    logic                  acc_b;
    logic [1:0]            wr_n;
    trace_rec_type         wr_d0;
    logic [1:0]            n_drop;
    logic [DROP_W:0]       drop_sum;
    logic [DROP_W-1:0]     drop_q;

    assign clk = gclk.clk;

`ifdef TRACE_TID_FILTER_EN
    assign pass_a = tid_mask[cm_rec.tid];
    assign pass_b = tid_mask[uc_rec.tid];
`else
    assign pass_a = 1'b1;
    assign pass_b = 1'b1;
`endif

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign free      = CW'(DEPTH) - count + CW'(pop);

    assign elig_a = (state_q == TS_RUN) && cm_valid && pass_a;
    assign elig_b = (state_q == TS_RUN) && uc_valid && pass_b;
    assign acc_a  = elig_a && (free != '0);
    assign acc_b  = elig_b && (acc_a ? (free >= CW'(2)) : (free != '0));

    // Port B slides into the first slot when port A is not written
    assign wr_n   = {1'b0, acc_a} + {1'b0, acc_b};
    assign wr_d0  = acc_a ? cm_rec : uc_rec;
    assign n_drop = {1'b0, elig_a & ~acc_a} + {1'b0, elig_b & ~acc_b};

    assign drop_sum = {1'b0, drop_q} + (DROP_W+1)'(n_drop);
    assign drop_cnt = drop_q;
    assign state    = state_q;

    trace_fifo_2w1r #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .wr_n  (wr_n),
        .wr_d0 (wr_d0),
        .wr_d1 (uc_rec),
        .rd_en (pop),
        .rd_d  (out_rec),
        .count (count),
        .empty (empty)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TS_IDLE:  if (trace_en) state_d = TS_RUN;
            TS_RUN:   if (!trace_en) state_d = TS_DRAIN;
            TS_DRAIN: begin
                if (trace_en)   state_d = TS_RUN;
                else if (empty) state_d = TS_IDLE;
            end
            default:  state_d = TS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= TS_IDLE;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        end
    end

endmodule

// File: tb/tb_trace_sched.sv
// Directed self-checking bench for trace_sched.
// Build with TRACE_TID_FILTER_EN to exercise the tid filter.
module tb_trace_sched;
    import libiu::*;

    logic          clk;
    iu_clk_type    gclk;
    logic          rstn;
    logic          trace_en;
    logic          cm_valid;
    trace_rec_type cm_rec;
    logic          uc_valid;
    trace_rec_type uc_rec;
    logic          out_valid;
    trace_rec_type out_rec;
    logic          out_ready;
    logic [15:0]   drop_cnt;
    logic [1:0]    state;
`ifdef TRACE_TID_FILTER_EN
    logic [63:0]   tid_mask;
`endif

    int checks;
    int errors;

    assign gclk.clk = clk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    trace_sched #(
        .DEPTH(8),
        .DROP_W(16)
    ) dut (
        .gclk      (gclk),
        .rstn      (rstn),
        .trace_en  (trace_en),
        .cm_valid  (cm_valid),
        .cm_rec    (cm_rec),
        .uc_valid  (uc_valid),
        .uc_rec    (uc_rec),
`ifdef TRACE_TID_FILTER_EN
        .tid_mask  (tid_mask),
`endif
        .out_valid (out_valid),
        .out_rec   (out_rec),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt),
        .state     (state)
    );

    function automatic trace_rec_type mk(input logic [5:0] tid,
                                         input logic [31:0] pc);
        trace_rec_type r;
        r.tid      = tid;
        r.pc       = pc;
        r.inst     = ~pc;
        r.upc      = pc[7:0] ^ 8'h5a;
        r.replay   = pc[0];
        r.annul    = pc[1];
        r.dma_mode = pc[2];
        r.uc_mode  = pc[3];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cm_valid  = 1'b0;
        uc_valid  = 1'b0;
        cm_rec    = '0;
        uc_rec    = '0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        trace_en = 1'b0;
        rstn     = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rstn = 1'b0;
        #2;
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got %0d want 0", state);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (drop_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_drop got %h want 0000", drop_cnt);
        end
        step();
        rstn = 1'b1;
    endtask

    task automatic test_single();
        trace_rec_type r;
        do_reset();
        trace_en = 1'b1;
        step();
        r = mk(6'd0, 32'h4000_0010);
        cm_valid = 1'b1;
        cm_rec   = r;
        step();
        cm_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_rec !== r) begin
            errors++;
            $display("FAIL single_out got v=%b pc=%h want v=1 pc=%h",
                     out_valid, out_rec.pc, r.pc);
        end
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL single_state got %0d want 1", state);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_fill_order();
        logic [31:0] exp_pc [8];
        exp_pc = '{32'h200, 32'h101, 32'h201, 32'h102,
                   32'h202, 32'h103, 32'h203, 32'h105};
        do_reset();
        trace_en = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            cm_valid = 1'b1;
            uc_valid = 1'b1;
            cm_rec   = mk(6'd0, 32'h100 + i);
            uc_rec   = mk(6'd0, 32'h200 + i);
            step();
        end
        checks++;
        if (drop_cnt !== 16'd0 || out_rec !== mk(6'd0, 32'h100)) begin
            errors++;
            $display("FAIL fill_8 got drop=%0d pc=%h want drop=0 pc=100",
                     drop_cnt, out_rec.pc);
        end
        cm_rec = mk(6'd0, 32'h104);
        uc_rec = mk(6'd0, 32'h204);
        step();
        checks++;
        if (drop_cnt !== 16'd2) begin
            errors++;
            $display("FAIL full_double_drop got %0d want 2", drop_cnt);
        end
        checks++;
        if (out_rec.pc !== 32'h100) begin
            errors++;
            $display("FAIL head_stable got %h want 100", out_rec.pc);
        end
        cm_rec    = mk(6'd0, 32'h105);
        uc_rec    = mk(6'd0, 32'h205);
        out_ready = 1'b1;
        step();
        cm_valid = 1'b0;
        uc_valid = 1'b0;
        checks++;
        if (drop_cnt !== 16'd3) begin
            errors++;
            $display("FAIL one_free_drop got %0d want 3", drop_cnt);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_rec.pc !== exp_pc[k]) begin
                errors++;
                $display("FAIL order_%0d got v=%b pc=%h want pc=%h",
                         k, out_valid, out_rec.pc, exp_pc[k]);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_empty got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        trace_en = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            cm_valid = 1'b1;
            uc_valid = 1'b1;
            cm_rec   = mk(6'd0, 32'(2 * i));
            uc_rec   = mk(6'd0, 32'(2 * i + 1));
            step();
        end
        uc_valid = 1'b0;
        cm_rec   = mk(6'd0, 32'd6);
        step();
        uc_valid  = 1'b1;
        cm_rec    = mk(6'd0, 32'd7);
        uc_rec    = mk(6'd0, 32'd8);
        out_ready = 1'b1;
        step();
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL b2b_no_drop got %0d want 0", drop_cnt);
        end
        out_ready = 1'b0;
        uc_valid  = 1'b0;
        cm_rec    = mk(6'd0, 32'd9);
        step();
        cm_valid = 1'b0;
        checks++;
        if (drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL b2b_now_full got %0d want 1", drop_cnt);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_rec.pc !== 32'(k)) begin
                errors++;
                $display("FAIL b2b_order_%0d got v=%b pc=%h want %h",
                         k, out_valid, out_rec.pc, 32'(k));
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_drain();
        do_reset();
        trace_en = 1'b1;
        step();
        cm_valid = 1'b1;
        uc_valid = 1'b1;
        cm_rec   = mk(6'd0, 32'h10);
        uc_rec   = mk(6'd0, 32'h11);
        step();
        uc_valid = 1'b0;
        cm_rec   = mk(6'd0, 32'h12);
        step();
        cm_valid = 1'b0;
        trace_en = 1'b0;
        step();
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL drain_enter got %0d want 2", state);
        end
        cm_valid  = 1'b1;
        uc_valid  = 1'b1;
        cm_rec    = mk(6'd0, 32'hdead);
        uc_rec    = mk(6'd0, 32'hbeef);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (state !== 2'd2 || out_valid !== 1'b1 ||
                out_rec.pc !== 32'h10 + k) begin
                errors++;
                $display("FAIL drain_pop_%0d got st=%0d v=%b pc=%h want st=2 pc=%h",
                         k, state, out_valid, out_rec.pc, 32'h10 + k);
            end
            step();
        end
        checks++;
        if (state !== 2'd2 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_last got st=%0d v=%b want st=2 v=0",
                     state, out_valid);
        end
        step();
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL drain_idle got %0d want 0", state);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL drain_ignored got v=%b drop=%0d want v=0 drop=0",
                     out_valid, drop_cnt);
        end
    endtask

    task automatic test_drain_rerun_reset();
        do_reset();
        trace_en = 1'b1;
        step();
        cm_valid = 1'b1;
        cm_rec   = mk(6'd0, 32'h77);
        step();
        cm_valid = 1'b0;
        trace_en = 1'b0;
        step();
        trace_en = 1'b1;
        step();
        checks++;
        if (state !== 2'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_rerun got st=%0d v=%b want st=1 v=1",
                     state, out_valid);
        end
        trace_en = 1'b0;
        step();
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL drain_again got %0d want 2", state);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_reset got st=%0d v=%b want st=0 v=0",
                     state, out_valid);
        end
        step();
        rstn = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || state !== 2'd0) begin
            errors++;
            $display("FAIL post_reset got st=%0d v=%b want st=0 v=0",
                     state, out_valid);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        trace_en = 1'b1;
        step();
        cm_valid = 1'b1;
        uc_valid = 1'b1;
        cm_rec   = mk(6'd0, 32'h1);
        uc_rec   = mk(6'd0, 32'h2);
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 32767; i++) step();
        checks++;
        if (drop_cnt !== 16'hfffe) begin
            errors++;
            $display("FAIL sat_pre got %h want fffe", drop_cnt);
        end
        step();
        checks++;
        if (drop_cnt !== 16'hffff) begin
            errors++;
            $display("FAIL sat_hit got %h want ffff", drop_cnt);
        end
        step();
        cm_valid = 1'b0;
        uc_valid = 1'b0;
        checks++;
        if (drop_cnt !== 16'hffff) begin
            errors++;
            $display("FAIL sat_hold got %h want ffff", drop_cnt);
        end
    endtask

`ifdef TRACE_TID_FILTER_EN
    task automatic test_tid_filter();
        tid_mask = 64'h1;
        do_reset();
        trace_en = 1'b1;
        step();
        cm_valid = 1'b1;
        uc_valid = 1'b1;
        cm_rec   = mk(6'd1, 32'h31);
        uc_rec   = mk(6'd0, 32'h30);
        step();
        cm_valid = 1'b0;
        uc_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_rec.pc !== 32'h30 ||
            drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL tid_pass got v=%b pc=%h drop=%0d want pc=30 drop=0",
                     out_valid, out_rec.pc, drop_cnt);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL tid_filtered got v=%b want 0", out_valid);
        end
        out_ready = 1'b0;
        cm_valid  = 1'b1;
        uc_valid  = 1'b1;
        cm_rec    = mk(6'd0, 32'h40);
        uc_rec    = mk(6'd0, 32'h41);
        for (int i = 0; i < 4; i++) step();
        cm_rec = mk(6'd1, 32'h50);
        uc_rec = mk(6'd1, 32'h51);
        step();
        cm_valid = 1'b0;
        uc_valid = 1'b0;
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL tid_no_drop got %0d want 0", drop_cnt);
        end
        tid_mask = '1;
    endtask
`endif

    initial begin
`ifdef TRACE_TID_FILTER_EN
        tid_mask = '1;
`endif
        checks   = 0;
        errors   = 0;
        rstn     = 1'b0;
        trace_en = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_fill_order();
        test_back_to_back();
        test_drain();
        test_drain_rerun_reset();
        test_saturate();
`ifdef TRACE_TID_FILTER_EN
        test_tid_filter();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
